// File: rtl/ctrl_ramdrv_sched.sv
// Tap-address sequencer for one filter pass: loads the vector length into the header bank,
// reads the head offset, walks the circular buffer backwards under a ready handshake, then advances the head.
module ctrl_ramdrv_sched #(
  parameter int DATA_OFFSET_WIDTH  = 10,
  parameter int VECTOR_INDEX_WIDTH = 4,
  parameter int ADDR_WIDTH         = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [VECTOR_INDEX_WIDTH-1:0] vec_index,
  input  logic [DATA_OFFSET_WIDTH-1:0]  vec_length,
  input  logic [ADDR_WIDTH-1:0]         vec_base,
  output logic                          hdr_init,
  output logic                          hdr_head_inc,
  output logic                          hdr_read_reg,
  output logic [VECTOR_INDEX_WIDTH-1:0] hdr_index,
  output logic [DATA_OFFSET_WIDTH-1:0]  hdr_length,
  input  logic [DATA_OFFSET_WIDTH-1:0]  hdr_head_offset,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic                          ram_valid,
  input  logic                          ram_ready,
  output logic                          tap_first,
  output logic                          tap_last,
  output logic                          busy,
  output logic                          done
);

  typedef enum logic [2:0] {
    IDLE, LOAD_LEN, READ_HEAD, ISSUE, INC_HEAD, DONE
  } state_t;

  state_t                       state;
  logic [ADDR_WIDTH-1:0]        base_reg;
  logic [DATA_OFFSET_WIDTH-1:0] ptr_reg;
  logic [DATA_OFFSET_WIDTH-1:0] tap_cnt_reg;
  logic [DATA_OFFSET_WIDTH-1:0] ptr_next;
  logic [DATA_OFFSET_WIDTH-1:0] tap_cnt_next;

  // Walking backwards: offset 0 wraps to the last valid offset of the buffer.
  always_comb begin
    ptr_next     = (ptr_reg == '0) ? hdr_length : ptr_reg - 1'b1;
    tap_cnt_next = tap_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      base_reg     <= '0;
      ptr_reg      <= '0;
      tap_cnt_reg  <= '0;
      hdr_init     <= 1'b0;
      hdr_head_inc <= 1'b0;
      hdr_read_reg <= 1'b0;
      hdr_index    <= '0;
      hdr_length   <= '0;
      ram_addr     <= '0;
      ram_valid    <= 1'b0;
      tap_first    <= 1'b0;
      tap_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            hdr_index  <= vec_index;
            hdr_length <= vec_length;
            base_reg   <= vec_base;
            hdr_init   <= 1'b1;
            busy       <= 1'b1;
            state      <= LOAD_LEN;
          end
        end
        LOAD_LEN: begin
          hdr_init     <= 1'b0;
          hdr_read_reg <= 1'b1;
          state        <= READ_HEAD;
        end
        READ_HEAD: begin
          // The head offset is only driven during this cycle, so the first address is built from it directly.
          hdr_read_reg <= 1'b0;
          ptr_reg      <= hdr_head_offset;
          tap_cnt_reg  <= '0;
          ram_valid    <= 1'b1;
          ram_addr     <= base_reg + ADDR_WIDTH'(hdr_head_offset);
          tap_first    <= 1'b1;
          tap_last     <= (hdr_length == '0);
          state        <= ISSUE;
        end
        ISSUE: begin
          if (ram_ready) begin
            ptr_reg     <= ptr_next;
            tap_cnt_reg <= tap_cnt_next;
            tap_first   <= 1'b0;
            if (tap_last) begin
              ram_valid    <= 1'b0;
              ram_addr     <= '0;
              tap_last     <= 1'b0;
              hdr_head_inc <= 1'b1;
              state        <= INC_HEAD;
            end else begin
              ram_addr <= base_reg + ADDR_WIDTH'(ptr_next);
              tap_last <= (tap_cnt_next == hdr_length);
            end
          end
        end
        INC_HEAD: begin
          hdr_head_inc <= 1'b0;
          done         <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_ramdrv_sched.sv
// Directed bench for ctrl_ramdrv_sched with a behavioural header bank and a table of hand-computed passes.
module tb_ctrl_ramdrv_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  vec_index = '0;
  logic [9:0]  vec_length = '0;
  logic [13:0] vec_base = '0;
  logic        hdr_init, hdr_head_inc, hdr_read_reg;
  logic [3:0]  hdr_index;
  logic [9:0]  hdr_length;
  logic [9:0]  hdr_head_offset;
  logic [13:0] ram_addr;
  logic        ram_valid;
  logic        ram_ready = 1'b1;
  logic        tap_first, tap_last, busy, done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_ramdrv_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .vec_index(vec_index), .vec_length(vec_length), .vec_base(vec_base),
    .hdr_init(hdr_init), .hdr_head_inc(hdr_head_inc), .hdr_read_reg(hdr_read_reg),
    .hdr_index(hdr_index), .hdr_length(hdr_length), .hdr_head_offset(hdr_head_offset),
    .ram_addr(ram_addr), .ram_valid(ram_valid), .ram_ready(ram_ready),
    .tap_first(tap_first), .tap_last(tap_last), .busy(busy), .done(done)
  );

  // Header bank model; outside a read it drives junk so a mistimed capture shows up.
  logic [9:0] head_m [16];
  logic [9:0] len_m  [16];
  logic       seed_en = 1'b0;
  logic [3:0] seed_idx = '0;
  logic [9:0] seed_val = '0;

  assign hdr_head_offset = hdr_read_reg ? head_m[hdr_index] : 10'h3A5;

  always @(posedge clk) begin
    if (seed_en) head_m[seed_idx] <= seed_val;
    else if (!rst) begin
      if (hdr_init) len_m[hdr_index] <= hdr_length;
      if (hdr_head_inc)
        head_m[hdr_index] <= (head_m[hdr_index] == len_m[hdr_index]) ? 10'd0 : head_m[hdr_index] + 10'd1;
    end
  end

  typedef struct packed {
    int idx; int len; int base; int head;
    int stall_tap; int stall_n; int ign_tap; int chain;
    int inc_cyc; int done_cyc;
    logic [13:0] a0; logic [13:0] a1; logic [13:0] a2; logic [13:0] a3; logic [13:0] a4;
  } vec_t;

  function automatic vec_t mk(int idx, int len, int base, int head, int stall_tap, int stall_n,
                              int ign_tap, int chain, int inc_cyc, int done_cyc,
                              int a0, int a1, int a2, int a3, int a4);
    vec_t v;
    v.idx = idx; v.len = len; v.base = base; v.head = head;
    v.stall_tap = stall_tap; v.stall_n = stall_n; v.ign_tap = ign_tap; v.chain = chain;
    v.inc_cyc = inc_cyc; v.done_cyc = done_cyc;
    v.a0 = 14'(a0); v.a1 = 14'(a1); v.a2 = 14'(a2); v.a3 = 14'(a3); v.a4 = 14'(a4);
    return v;
  endfunction

  function automatic logic [13:0] exp_addr(vec_t v, int t);
    case (t)
      0: return v.a0;
      1: return v.a1;
      2: return v.a2;
      3: return v.a3;
      default: return v.a4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic run_pass(input int n, input vec_t v);
    int taps, stall_rem, inc_seen, done_seen;
    bit ign_done, ready_now;
    taps = 0; stall_rem = v.stall_n; inc_seen = 0; done_seen = 0; ign_done = 0;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 0);
    chk("idle_outs", {27'd0, hdr_init, hdr_head_inc, hdr_read_reg, done, ram_valid}, 0);
    if (v.head >= 0) begin
      seed_en = 1'b1; seed_idx = 4'(v.idx); seed_val = 10'(v.head);
    end
    vec_index = 4'(v.idx); vec_length = 10'(v.len); vec_base = 14'(v.base);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; seed_en = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      ready_now = 1'b1;
      if (ram_valid && taps == v.stall_tap && stall_rem > 0) begin
        ready_now = 1'b0;
        stall_rem--;
        chk("stall_hold_addr", {18'd0, ram_addr}, {18'd0, exp_addr(v, taps)});
      end
      if (ram_valid && taps == v.ign_tap && !ign_done) begin
        ign_done = 1; start = 1'b1;
        vec_index = 4'd9; vec_length = 10'd1; vec_base = 14'h2000;
      end
      ram_ready = ready_now;
      chk("strobe_onehot0", {31'd0, ($countones({hdr_init, hdr_head_inc, hdr_read_reg}) <= 1)}, 1);
      chk("busy_in_pass", {31'd0, busy}, 1);
      chk("index_held", {28'd0, hdr_index}, 32'(v.idx));
      if (cyc == 1) begin
        chk("load_len_init", {31'd0, hdr_init}, 1);
        chk("load_len_length", {22'd0, hdr_length}, 32'(v.len));
      end
      if (cyc == 2) chk("read_head_strobe", {31'd0, hdr_read_reg}, 1);
      if (ram_valid) chk("issue_strobes_zero", {29'd0, hdr_init, hdr_head_inc, hdr_read_reg}, 0);
      if (ram_valid && ready_now) begin
        chk("tap_addr", {18'd0, ram_addr}, {18'd0, exp_addr(v, taps)});
        chk("tap_first", {31'd0, tap_first}, {31'd0, taps == 0});
        chk("tap_last", {31'd0, tap_last}, {31'd0, taps == v.len});
        taps++;
      end
      if (hdr_head_inc) inc_seen = cyc;
      if (done) begin
        done_seen = cyc;
        if (v.chain != 0) start = 1'b1;
        break;
      end
    end
    ram_ready = 1'b1;
    chk("tap_count", 32'(taps), 32'(v.len + 1));
    chk("inc_cycle", 32'(inc_seen), 32'(v.inc_cyc));
    chk("done_cycle", 32'(done_seen), 32'(v.done_cyc));
    $display("pass %0d idx=%0d len=%0d base=%0h taps=%0d inc@%0d done@%0d", n, v.idx, v.len, v.base,
             taps, inc_seen, done_seen);
  endtask

  vec_t vecs [9];

  initial begin
    int seen;
    vecs[0] = mk(3, 4, 'h100, 2, -1, 0, -1, 0, 8, 9, 'h102, 'h101, 'h100, 'h104, 'h103);
    vecs[1] = mk(5, 4, 'h000, 0, -1, 0, -1, 0, 8, 9, 'h000, 'h004, 'h003, 'h002, 'h001);
    vecs[2] = mk(7, 0, 'h3FFF, 0, -1, 0, -1, 0, 4, 5, 'h3FFF, 0, 0, 0, 0);
    vecs[3] = mk(1, 4, 'h3FFE, 3, -1, 0, -1, 0, 8, 9, 'h0001, 'h0000, 'h3FFF, 'h3FFE, 'h0002);
    vecs[4] = mk(3, 4, 'h100, 2, 1, 3, -1, 0, 11, 12, 'h102, 'h101, 'h100, 'h104, 'h103);
    vecs[5] = mk(3, 4, 'h100, 2, -1, 0, 2, 0, 8, 9, 'h102, 'h101, 'h100, 'h104, 'h103);
    vecs[6] = mk(3, 4, 'h100, 2, -1, 0, -1, 1, 8, 9, 'h102, 'h101, 'h100, 'h104, 'h103);
    vecs[7] = mk(3, 4, 'h100, -1, -1, 0, -1, 1, 8, 9, 'h103, 'h102, 'h101, 'h100, 'h104);
    vecs[8] = mk(3, 4, 'h100, -1, -1, 0, -1, 0, 8, 9, 'h104, 'h103, 'h102, 'h101, 'h100);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {12'd0, hdr_init, hdr_head_inc, hdr_read_reg, hdr_index, ram_valid,
                       tap_first, tap_last, busy, done}, 0);
    chk("reset_len_addr", {8'd0, hdr_length, ram_addr}, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_pass(i, vecs[i]);
      if (vecs[i].ign_tap >= 0) begin
        seen = 0;
        repeat (10) begin
          @(negedge clk);
          if (busy || hdr_init || ram_valid || done) seen = 1;
        end
        chk("ignored_start_no_pass", 32'(seen), 0);
      end
    end
    @(negedge clk);
    chk("b2b_head_wrapped", {22'd0, head_m[3]}, 0);

    // Reset on the second ISSUE cycle of a pass.
    seed_en = 1'b1; seed_idx = 4'd3; seed_val = 10'd2;
    vec_index = 4'd3; vec_length = 10'd4; vec_base = 14'h100;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; seed_en = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_in_issue", {31'd0, ram_valid}, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_outs", {12'd0, hdr_init, hdr_head_inc, hdr_read_reg, hdr_index, ram_valid,
                     tap_first, tap_last, busy, done}, 0);
    chk("rst_len_addr", {8'd0, hdr_length, ram_addr}, 0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (hdr_head_inc || done || busy) seen = 1;
    end
    chk("rst_no_inc_done", 32'(seen), 0);
    chk("rst_head_kept", {22'd0, head_m[3]}, 2);
    $display("reset sequence complete");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
